burst_seq_gen: RTL and testbench

Parametrised burst address sequencer for the SPI-to-MRAM path, the next generation of the single/burst controller. It receives a serial header of burst length and start address, then issues one address per beat to the downstream address serialiser over a valid/ready handshake. It supports single, incrementing, wrapping and fixed bursts, with abort and error reporting. It sits between the SPI command decoder and the address parallel-to-serial output stage.

---
 rtl/burst_seq_pkg.sv | 23 ++
 rtl/hdr_stp.sv | 44 ++++
 rtl/burst_seq_gen.sv | 152 +++++++++++++++
 tb/tb_burst_seq_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_seq_pkg.sv
// rtl/burst_seq_pkg.sv - shared types and constants for the burst address sequencer
//   state_t    : sequencer FSM states
//   MODE_*     : burst mode encodings carried on the mode input
//   hdr_bits() : serial header length (length field + address field)
package burst_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_HDR,
    S_ISSUE,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_INCR   = 2'b01;
  localparam logic [1:0] MODE_WRAP   = 2'b10;
  localparam logic [1:0] MODE_FIXED  = 2'b11;

  function automatic int hdr_bits(input int len_w, input int addr_w);
    return len_w + addr_w;
  endfunction

endpackage

// File: rtl/hdr_stp.sv
// rtl/hdr_stp.sv - serial-to-parallel header shift register with bit counter
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : hold the bit counter at zero (sequencer not collecting a header)
//   shift      : accept bit on this cycle
//   bit_in     : serial data, MSB first
//   word       : assembled header including the bit presented this cycle
//   full       : one-cycle pulse, high while the final header bit is being shifted
module hdr_stp #(
  parameter int W = 30
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         shift,
  input  logic         bit_in,
  output logic [W-1:0] word,
  output logic         full
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  // Only W-1 bits are stored: the final bit is taken straight from bit_in so
  // the sequencer can load the header on the same edge that samples it.
  logic [W-2:0]  sr;
  logic [CW-1:0] cnt;

  assign word = {sr, bit_in};
  assign full = shift && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (shift) begin
      sr  <= word[W-2:0];
      cnt <= full ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/burst_seq_gen.sv
// rtl/burst_seq_gen.sv - burst address sequencer: serial header in, one address per beat out
//   clk, rst_n     : clock, asynchronous active-low reset
//   en             : global enable, 0 freezes all state
//   start, mode    : burst request and mode (single/incr/wrap/fixed)
//   abort          : synchronous abort back to idle
//   ser_in/valid   : serial header, length field then address field, MSB first
//   single_addr_in : address for single-beat transfers
//   addr_out/valid/ready : beat address handshake to the serialiser
//   beat_cnt       : beats accepted in current burst
//   busy, done, err: status (err = illegal wrap length, burst ran as incr)
module burst_seq_gen
  import burst_seq_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 6,
  parameter int STEP   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              abort,
  input  logic              ser_in,
  input  logic              ser_valid,
  input  logic [ADDR_W-1:0] single_addr_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [LEN_W:0]    beat_cnt,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int HW = hdr_bits(LEN_W, ADDR_W);
  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);
  localparam logic [LEN_W:0]    ONE_L  = {{LEN_W{1'b0}}, 1'b1};

  state_t            state;
  logic [1:0]        mode_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W:0]    beats_left;

  logic [HW-1:0]     hdr_word;
  logic              hdr_full;
  logic [LEN_W-1:0]  hdr_len;
  logic [ADDR_W-1:0] hdr_addr;
  logic [LEN_W:0]    len_ext;
  logic              wrap_ok;

  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] addr_next;

  hdr_stp #(.W(HW)) u_hdr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state != S_LOAD_HDR),
    .shift  (en && !abort && ser_valid && (state == S_LOAD_HDR)),
    .bit_in (ser_in),
    .word   (hdr_word),
    .full   (hdr_full)
  );

  assign hdr_len  = hdr_word[HW-1 -: LEN_W];
  assign hdr_addr = hdr_word[ADDR_W-1:0];
  assign len_ext  = {1'b0, hdr_len};
  // Wrap needs a power-of-two beat count so len doubles as the offset mask.
  assign wrap_ok  = ((len_ext + ONE_L) & len_ext) == '0;

  always_comb begin
    addr_inc = addr_out + STEP_A;
    mask     = ADDR_W'(len_q);
    case (mode_q)
      MODE_FIXED: addr_next = addr_out;
      MODE_WRAP:  addr_next = (addr_out & ~mask) | (addr_inc & mask);
      default:    addr_next = addr_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mode_q     <= MODE_SINGLE;
      len_q      <= '0;
      beats_left <= '0;
      addr_out   <= '0;
      addr_valid <= 1'b0;
      beat_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else if (abort) begin
      state      <= S_IDLE;
      addr_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (en) begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            beat_cnt <= '0;
            err      <= 1'b0;
            busy     <= 1'b1;
            mode_q   <= mode;
            if (mode == MODE_SINGLE) begin
              addr_out   <= single_addr_in;
              beats_left <= ONE_L;
              addr_valid <= 1'b1;
              state      <= S_ISSUE;
            end else begin
              state <= S_LOAD_HDR;
            end
          end
        end
        S_LOAD_HDR: begin
          if (hdr_full) begin
            addr_out   <= hdr_addr;
            len_q      <= hdr_len;
            beats_left <= len_ext + ONE_L;
            addr_valid <= 1'b1;
            state      <= S_ISSUE;
            if (mode_q == MODE_WRAP && !wrap_ok) begin
              err    <= 1'b1;
              mode_q <= MODE_INCR;
            end
          end
        end
        S_ISSUE: begin
          if (addr_valid && addr_ready) begin
            beat_cnt   <= beat_cnt + ONE_L;
            beats_left <= beats_left - ONE_L;
            addr_out   <= addr_next;
            if (beats_left == ONE_L) begin
              addr_valid <= 1'b0;
              done       <= 1'b1;
              state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_seq_gen.sv
// tb/tb_burst_seq_gen.sv - directed bench with address scoreboard for burst_seq_gen
module tb_burst_seq_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        abort = 1'b0;
  logic        ser_in = 1'b0;
  logic        ser_valid = 1'b0;
  logic [23:0] single_addr_in = '0;
  logic [23:0] addr_out;
  logic        addr_valid;
  logic        addr_ready = 1'b1;
  logic [6:0]  beat_cnt;
  logic        busy;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [23:0] sb[$];

  logic        hs;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_addr = '0;

  burst_seq_gen #(.ADDR_W(24), .LEN_W(6), .STEP(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .start          (start),
    .mode           (mode),
    .abort          (abort),
    .ser_in         (ser_in),
    .ser_valid      (ser_valid),
    .single_addr_in (single_addr_in),
    .addr_out       (addr_out),
    .addr_valid     (addr_valid),
    .addr_ready     (addr_ready),
    .beat_cnt       (beat_cnt),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference address for beat i; wrap uses an aligned window and modulo offset.
  function automatic logic [23:0] model_addr(input logic [1:0] m, input int len,
                                             input logic [23:0] a, input int i);
    int beats;
    int ai;
    int base;
    beats = len + 1;
    ai    = int'(a);
    if (m == 2'b11) return a;
    if (m == 2'b10 && ((beats & len) == 0)) begin
      base = ai - (ai % beats);
      return 24'(base + ((ai - base + i) % beats));
    end
    return 24'(ai + i);
  endfunction

  task automatic push_exp(input logic [1:0] m, input int len, input logic [23:0] a, input int count);
    for (int i = 0; i < count; i++) sb.push_back(model_addr(m, len, a, i));
  endtask

  // Scoreboard and hold checks, sampled mid-cycle away from the rising edge.
  always @(negedge clk) begin
    hs = rst_n && en && !abort && addr_valid && addr_ready;
    if (rst_n && prev_stall) check("valid_hold", {7'd0, addr_valid, addr_out}, {7'd0, 1'b1, prev_addr});
    if (hs) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL sb_extra_beat: observed %0h expected none", addr_out);
      end else begin
        check("beat_addr", addr_out, sb.pop_front());
      end
    end
    prev_stall = rst_n && addr_valid && !hs && !abort;
    prev_addr  = addr_out;
  end

  task automatic send_hdr(input int len, input logic [23:0] a, input bit stall);
    logic [29:0] h;
    int k;
    h = {6'(len), a};
    for (int i = 29; i >= 0; i--) begin
      if (stall) begin
        k = $urandom_range(0, 2);
        repeat (k) begin
          if ($urandom_range(0, 1) == 1) begin
            en = 1'b1; ser_valid = 1'b0;
          end else begin
            en = 1'b0; ser_valid = 1'b1; ser_in = ~h[i];
          end
          tick;
        end
      end
      en = 1'b1; ser_valid = 1'b1; ser_in = h[i];
      tick;
      if (i > 0) check("hdr_no_valid", addr_valid, 1'b0);
    end
    ser_valid = 1'b0;
    check("hdr_to_valid", addr_valid, 1'b1);
  endtask

  task automatic drain(input bit rnd, input int beats);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 500) begin
      if (rnd) begin
        addr_ready = 1'($urandom_range(0, 1));
        en = ($urandom_range(0, 3) != 0);
      end
      tick;
      n++;
    end
    en = 1'b1;
    addr_ready = 1'b1;
    check("done_seen", done, 1'b1);
    if (!rnd) check("no_bubbles", n, beats);
    check("beat_cnt", beat_cnt, 7'(beats));
    check("busy_in_done", busy, 1'b1);
    check("sb_drained", sb.size(), 0);
    tick;
    check("done_pulse_end", done, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("valid_idle", addr_valid, 1'b0);
  endtask

  task automatic run_burst(input logic [1:0] m, input int len, input logic [23:0] a, input bit rnd);
    push_exp(m, len, a, len + 1);
    mode = m; start = 1'b1;
    tick;
    start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_no_valid", addr_valid, 1'b0);
    send_hdr(len, a, rnd);
    check("err_flag", err, (m == 2'b10 && (((len + 1) & len) != 0)));
    drain(rnd, len + 1);
  endtask

  initial begin
    repeat (2) tick;
    check("rst_addr_out", addr_out, 0);
    check("rst_addr_valid", addr_valid, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    tick;

    // abort wins over start in IDLE
    mode = 2'b01; start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    check("abort_vs_start", busy, 1'b0);
    tick;

    // single transfer
    single_addr_in = 24'h00ABCD;
    sb.push_back(24'h00ABCD);
    mode = 2'b00; start = 1'b1;
    tick;
    start = 1'b0;
    check("single_valid", addr_valid, 1'b1);
    drain(1'b0, 1);

    run_burst(2'b01, 3, 24'h000010, 1'b0);
    run_burst(2'b01, 3, 24'hFFFFFE, 1'b0);
    run_burst(2'b10, 3, 24'h00000E, 1'b0);
    run_burst(2'b10, 4, 24'h00000E, 1'b0);
    check("err_held", err, 1'b1);
    run_burst(2'b11, 7, 24'h000040, 1'b0);

    // backpressure, enable freeze and header stalls
    run_burst(2'b01, 5, 24'h000100, 1'b1);
    run_burst(2'b10, 7, 24'h00003C, 1'b1);
    run_burst(2'b11, 2, 24'h000777, 1'b1);
    run_burst(2'b01, 9, 24'hFFFFFB, 1'b1);

    // abort after two of eight beats
    push_exp(2'b01, 7, 24'h000200, 2);
    mode = 2'b01; start = 1'b1;
    tick;
    start = 1'b0;
    send_hdr(7, 24'h000200, 1'b0);
    tick;
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort_valid", addr_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_beat_cnt", beat_cnt, 7'd2);
    check("abort_sb", sb.size(), 0);
    repeat (3) begin
      tick;
      check("abort_no_done", done, 1'b0);
    end

    // asynchronous reset mid-header
    mode = 2'b01; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ser_valid = 1'b1; ser_in = 1'($urandom_range(0, 1));
      tick;
    end
    ser_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_addr_out", addr_out, 0);
    check("arst_beat_cnt", beat_cnt, 0);
    check("arst_busy", busy, 0);
    check("arst_valid", {done, err, addr_valid}, 0);
    tick;
    rst_n = 1'b1;
    tick;
    run_burst(2'b01, 1, 24'h000055, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
